// File: rtl/pipeline_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : pipeline_pkg                                                 |
// | Purpose   : Shared pipeline definitions: register index width,           |
// |             instruction-type encodings and the decode scoreboard FSM     |
// |             state encoding.                                              |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package pipeline_pkg;

  localparam int REG_IDX_W = 5;
  localparam int ITYPE_W   = 5;

  localparam logic [ITYPE_W-1:0] ITYPE_NOOP     = 5'd0;
  localparam logic [ITYPE_W-1:0] ITYPE_LOAD_IMM = 5'd1;
  localparam logic [ITYPE_W-1:0] ITYPE_LOAD_MEM = 5'd2;
  localparam logic [ITYPE_W-1:0] ITYPE_STORE    = 5'd3;
  localparam logic [ITYPE_W-1:0] ITYPE_ALU_OP   = 5'd4;
  localparam logic [ITYPE_W-1:0] ITYPE_JUMP     = 5'd5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HAZARD    = 2'd1,
    ST_JUMP_WAIT = 2'd2
  } state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/reg_inflight_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : reg_inflight_counter                                         |
// | Purpose   : Counts outstanding writes to one architectural register.     |
// |             inc and dec together leave the count unchanged; inc at the   |
// |             maximum and dec at zero are ignored (saturating).            |
// | Ports     : clk, rst (sync, active-high), inc, dec                       |
// |             is_zero / is_max - count flags                               |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module reg_inflight_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic is_zero,
  output logic is_max
);

  logic [CNT_W-1:0] cnt_q;

  assign is_zero = (cnt_q == '0);
  assign is_max  = &cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && !dec && !is_max) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule : reg_inflight_counter
`default_nettype wire

// File: rtl/decode_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : decode_hazard_scoreboard                                     |
// | Purpose   : Tracks in-flight register writes and stalls decode on RAW    |
// |             hazards, on WAW counter overflow and for the jump penalty.   |
// | Ports     : clk, rst            - clock, sync active-high reset          |
// |             dec_*               - decoder fields for the current instr   |
// |             wb_valid, wb_reg    - write-back retire event                |
// |             issue, stall        - decode advances / insert NOP           |
// |             fetch_hold          - fetch holds PC/instruction             |
// |             state, busy_regs    - debug state, per-register busy flags   |
// |             wb_underflow        - sticky retire-without-pending flag     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module decode_hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = 2,
  parameter int JUMP_PENALTY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [ITYPE_W-1:0]   dec_itype,
  input  logic [REG_IDX_W-1:0] dec_src0,
  input  logic                 dec_src0_used,
  input  logic [REG_IDX_W-1:0] dec_src1,
  input  logic                 dec_src1_used,
  input  logic [REG_IDX_W-1:0] dec_dst,
  input  logic                 dec_dst_used,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_reg,
  output logic                 issue,
  output logic                 stall,
  output logic                 fetch_hold,
  output logic [1:0]           state,
  output logic [NUM_REGS-1:0]  busy_regs,
  output logic                 wb_underflow
);

  localparam int JCNT_W = (JUMP_PENALTY > 1) ? $clog2(JUMP_PENALTY) : 1;
  localparam logic [JCNT_W-1:0] JCNT_LOAD = JCNT_W'(JUMP_PENALTY - 1);

  state_t              state_q;
  state_t              next_state;
  logic [JCNT_W-1:0]   jcnt_q;
  logic                hazard;
  logic                underflow_q;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] zero_vec;
  logic [NUM_REGS-1:0] max_vec;

  // One in-flight counter per architectural register; register 0 included.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign inc_vec[r] = issue & dec_dst_used & (dec_dst == REG_IDX_W'(r));
    assign dec_vec[r] = wb_valid & (wb_reg == REG_IDX_W'(r));

    reg_inflight_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_vec[r]),
      .dec     (dec_vec[r]),
      .is_zero (zero_vec[r]),
      .is_max  (max_vec[r])
    );
  end

  // Uses registered counts only: a write-back in this cycle clears the
  // hazard one cycle later, matching register-file write-on-edge timing.
  assign hazard = (dec_src0_used & ~zero_vec[dec_src0])
                | (dec_src1_used & ~zero_vec[dec_src1])
                | (dec_dst_used  &  max_vec[dec_dst]);

  always_comb begin
    next_state = state_q;
    issue      = 1'b0;
    stall      = 1'b0;
    fetch_hold = 1'b0;
    case (state_q)
      ST_RUN: begin
        issue      = dec_valid & ~hazard;
        stall      = dec_valid & hazard;
        fetch_hold = dec_valid & hazard;
        if (dec_valid && hazard) begin
          next_state = ST_HAZARD;
        end else if (issue && (dec_itype == ITYPE_JUMP)) begin
          next_state = ST_JUMP_WAIT;
        end
      end
      ST_HAZARD: begin
        stall      = 1'b1;
        fetch_hold = 1'b1;
        if (!hazard) begin
          next_state = ST_RUN;
        end
      end
      ST_JUMP_WAIT: begin
        // Fetch is redirecting, so it is not held during the bubbles.
        stall = 1'b1;
        if (jcnt_q == '0) begin
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      jcnt_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if ((state_q == ST_RUN) && (next_state == ST_JUMP_WAIT)) begin
        jcnt_q <= JCNT_LOAD;
      end else if ((state_q == ST_JUMP_WAIT) && (jcnt_q != '0)) begin
        jcnt_q <= jcnt_q - JCNT_W'(1);
      end
      if (wb_valid && zero_vec[wb_reg]) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign state        = state_q;
  assign busy_regs    = ~zero_vec;
  assign wb_underflow = underflow_q;

endmodule : decode_hazard_scoreboard
`default_nettype wire

// File: tb/tb_decode_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_decode_hazard_scoreboard                                  |
// | Purpose   : Self-checking bench for decode_hazard_scoreboard: directed   |
// |             scenarios followed by random traffic, all checked each cycle |
// |             against a behavioural scoreboard model.                      |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_decode_hazard_scoreboard;
  import pipeline_pkg::*;

  localparam int NREG = 32;
  localparam int PEN  = 3;
  localparam int MAXC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            dec_valid;
  logic [4:0]      dec_itype;
  logic [4:0]      dec_src0;
  logic            dec_src0_used;
  logic [4:0]      dec_src1;
  logic            dec_src1_used;
  logic [4:0]      dec_dst;
  logic            dec_dst_used;
  logic            wb_valid;
  logic [4:0]      wb_reg;
  logic            issue;
  logic            stall;
  logic            fetch_hold;
  logic [1:0]      state;
  logic [NREG-1:0] busy_regs;
  logic            wb_underflow;

  always #5 clk = ~clk;

  decode_hazard_scoreboard #(
    .NUM_REGS     (NREG),
    .CNT_W        (2),
    .JUMP_PENALTY (PEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_itype     (dec_itype),
    .dec_src0      (dec_src0),
    .dec_src0_used (dec_src0_used),
    .dec_src1      (dec_src1),
    .dec_src1_used (dec_src1_used),
    .dec_dst       (dec_dst),
    .dec_dst_used  (dec_dst_used),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .issue         (issue),
    .stall         (stall),
    .fetch_hold    (fetch_hold),
    .state         (state),
    .busy_regs     (busy_regs),
    .wb_underflow  (wb_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending-write counts, a mode (0 run, 1 hazard wait,
  // 2 jump bubbles), remaining jump bubbles and the sticky underflow flag.
  int m_cnt [NREG];
  int m_mode;
  int m_jleft;
  bit m_uflow;
  bit m_ok = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic cyc(input bit r, input bit v, input logic [4:0] it,
                     input logic [4:0] s0, input bit s0u,
                     input logic [4:0] s1, input bit s1u,
                     input logic [4:0] d, input bit du,
                     input bit wv, input logic [4:0] wr);
    bit          haz, e_issue, e_stall, e_fh;
    logic [31:0] e_busy;
    @(negedge clk);
    rst = r; dec_valid = v; dec_itype = it;
    dec_src0 = s0; dec_src0_used = s0u; dec_src1 = s1; dec_src1_used = s1u;
    dec_dst = d; dec_dst_used = du; wb_valid = wv; wb_reg = wr;
    #1;
    haz = (s0u && m_cnt[s0] != 0) || (s1u && m_cnt[s1] != 0) || (du && m_cnt[d] == MAXC);
    e_issue = 1'b0; e_stall = 1'b1; e_fh = 1'b1;
    if (m_mode == 0) begin
      e_issue = v && !haz;
      e_stall = v && haz;
      e_fh    = v && haz;
    end else if (m_mode == 2) begin
      e_fh = 1'b0;
    end
    e_busy = '0;
    for (int k = 0; k < NREG; k++) e_busy[k] = (m_cnt[k] != 0);
    if (m_ok) begin
      check_eq("issue", issue, e_issue);
      check_eq("stall", stall, e_stall);
      check_eq("fetch_hold", fetch_hold, e_fh);
      check_eq("state", state, m_mode);
      check_eq("busy_regs", busy_regs, e_busy);
      check_eq("wb_underflow", wb_underflow, m_uflow);
    end
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < NREG; k++) m_cnt[k] = 0;
      m_mode = 0; m_jleft = 0; m_uflow = 1'b0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (wv && m_cnt[wr] == 0) m_uflow = 1'b1;
      if (e_issue && du) m_cnt[d]++;
      if (wv && m_cnt[wr] > 0) m_cnt[wr]--;
      case (m_mode)
        0: if (v && haz) m_mode = 1;
           else if (e_issue && it == ITYPE_JUMP) begin m_mode = 2; m_jleft = PEN; end
        1: if (!haz) m_mode = 0;
        default: begin m_jleft--; if (m_jleft == 0) m_mode = 0; end
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, ITYPE_NOOP, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb_only(input logic [4:0] wr);
    cyc(0, 0, ITYPE_NOOP, 0, 0, 0, 0, 0, 0, 1, wr);
  endtask

  initial begin
    logic [4:0] ra, rb, rd, rw;
    // Reset held two cycles with write-back active.
    cyc(1, 0, ITYPE_NOOP, 0, 0, 0, 0, 0, 0, 1, 5'd3);
    cyc(1, 0, ITYPE_NOOP, 0, 0, 0, 0, 0, 0, 1, 5'd3);
    idle(1);

    // RAW on r5.
    cyc(0, 1, ITYPE_ALU_OP, 0, 0, 0, 0, 5'd5, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, ITYPE_ALU_OP, 5'd5, 1, 0, 0, 5'd6, 0, 0, 0);
    cyc(0, 1, ITYPE_ALU_OP, 5'd5, 1, 0, 0, 5'd6, 0, 1, 5'd5);
    cyc(0, 1, ITYPE_ALU_OP, 5'd5, 1, 0, 0, 5'd6, 0, 0, 0);
    cyc(0, 1, ITYPE_ALU_OP, 5'd5, 1, 0, 0, 5'd6, 0, 0, 0);
    #1 check_eq("raw_busy5_clear", busy_regs[5], 1'b0);

    // WAW overflow on r7.
    for (int k = 0; k < 3; k++) cyc(0, 1, ITYPE_LOAD_IMM, 0, 0, 0, 0, 5'd7, 1, 0, 0);
    cyc(0, 1, ITYPE_LOAD_IMM, 0, 0, 0, 0, 5'd7, 1, 0, 0);
    cyc(0, 1, ITYPE_LOAD_IMM, 0, 0, 0, 0, 5'd7, 1, 1, 5'd7);
    cyc(0, 1, ITYPE_LOAD_IMM, 0, 0, 0, 0, 5'd7, 1, 0, 0);
    cyc(0, 1, ITYPE_LOAD_IMM, 0, 0, 0, 0, 5'd7, 1, 0, 0);
    cyc(0, 1, ITYPE_LOAD_IMM, 0, 0, 0, 0, 5'd7, 1, 0, 0);
    #1 check_eq("waw_full_stall", stall, 1'b1);
    for (int k = 0; k < 3; k++) wb_only(5'd7);
    idle(1);

    // Simultaneous increment and retire on r2.
    cyc(0, 1, ITYPE_ALU_OP, 0, 0, 0, 0, 5'd2, 1, 0, 0);
    cyc(0, 1, ITYPE_ALU_OP, 0, 0, 0, 0, 5'd2, 1, 1, 5'd2);
    #1 check_eq("simul_busy2", busy_regs[2], 1'b1);
    wb_only(5'd2);

    // Jump penalty, then a jump interrupted by reset.
    cyc(0, 1, ITYPE_JUMP, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < PEN + 1; k++) cyc(0, 1, ITYPE_ALU_OP, 0, 0, 0, 0, 5'd4, 0, 0, 0);
    cyc(0, 1, ITYPE_JUMP, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, ITYPE_NOOP, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, ITYPE_NOOP, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_eq("jump_rst_state", state, 2'd0);

    // Underflow on r9 is sticky.
    wb_only(5'd9);
    idle(2);
    #1 check_eq("uflow_sticky", wb_underflow, 1'b1);
    check_eq("uflow_busy9", busy_regs[9], 1'b0);
    cyc(1, 0, ITYPE_NOOP, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      rb = 5'($urandom_range(0, 5));
      rd = 5'($urandom_range(0, 5));
      rw = 5'($urandom_range(0, 5));
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
          5'($urandom_range(0, 5)),
          ra, 1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)),
          rd, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 4), rw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_decode_hazard_scoreboard
`default_nettype wire
